fifo_sync_wd: RTL and testbench
===============================

# fifo_sync_wd

Parametrised synchronous FIFO with write/read enables, status flags and sticky error flags, replacing the fixed 8-bit, 8-stage free-running delay line used so far. Data is stored only when written and released only when read, so producer and consumer may stall independently. It sits between byte-stream producers and consumers in the same clock domain. Width, depth and the almost-full threshold are set per instance.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of storage entries; power of two, >=2
- AFULL_LVL, DEPTH-2, level at or above which almost_full asserts (1..DEPTH)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- clr  in  1  synchronous flush: empties FIFO, clears error flags
- wr_en  in  1  write request
- din  in  WIDTH  write data, sampled on accepted write
- rd_en  in  1  read request
- dout  out  WIDTH  read data, registered
- empty  out  1  no entries stored
- full  out  1  DEPTH entries stored
- almost_full  out  1  count >= AFULL_LVL
- count  out  clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- ovf  out  1  sticky: write attempted while full and not accepted
- udf  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH array; write pointer and read pointer, each clog2(DEPTH) bits, wrap from DEPTH-1 to 0 naturally; count held in a separate register.
- Accepted write (wa) = wr_en & (!full | rd_en). Accepted read (ra) = rd_en & !empty.
- On wa: mem[wptr] <= din, wptr += 1. On ra: dout <= mem[rptr], rptr += 1.
- count next = count + wa - ra; flags derived from registered count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AFULL_LVL).
- Full with wr_en & rd_en: both accepted; dout receives the oldest word, the new word takes its slot; count stays DEPTH; ovf not set.
- Full with wr_en only: write dropped, din discarded, ovf <= 1.
- Empty with rd_en: read ignored, dout holds, udf <= 1; a simultaneous wr_en is accepted (count -> 1). No fall-through: data written into an empty FIFO is not readable in the same cycle.
- dout changes only on an accepted read; otherwise holds its last value.
- clr (synchronous, priority over wr_en/rd_en): wptr, rptr, count <= 0; ovf, udf <= 0; dout holds; memory contents not cleared.
- ovf/udf remain set until rst or clr.

## Timing
- Reset values: dout = 0, count = 0, empty = 1, full = 0, almost_full = 0 (AFULL_LVL >= 1), ovf = 0, udf = 0; pointers = 0. Reset mid-operation discards all contents immediately.
- Write latency: write at edge N -> empty deasserts and count increments after edge N; earliest accepted read at edge N+1.
- Read latency: read accepted at edge M -> dout valid after edge M (1 cycle from rd_en sample).
- Flags and count are registered outputs; no combinational path from wr_en/rd_en/din to any output.
- Throughput: one write and one read per cycle sustained, any fill level from 1 to DEPTH.

## Test plan
- Reset, then write 0x11..0x88 on 8 consecutive cycles (DEPTH=8) -> count steps 1..8, almost_full asserts at count 6, full after 8th edge; then 8 reads -> dout 0x11..0x88 in order, empty after last read, ovf=udf=0.
- Full FIFO, wr_en=1 with din=0xAA, rd_en=0 -> count stays 8, ovf=1, 0xAA never appears at dout; ovf stays 1 until clr.
- Full FIFO, wr_en=rd_en=1 with din=0xBB -> dout=0x11, count=8, ovf=0; after 7 further reads then one more, dout ends with 0xBB.
- Empty FIFO, rd_en=1 and wr_en=1 din=0x5C -> udf=1, dout unchanged, count=1; next-cycle read -> dout=0x5C, empty=1.
- Streaming 20 words with pointer wrap-around at mixed fill levels (random rd/wr enables) -> output sequence equals input sequence, count always matches scoreboard.
- Assert rst while count=5 -> all outputs return to reset values asynchronously; assert clr with count=3 and ovf=1 -> count=0, empty=1, ovf=0 after the edge, dout unchanged.

Source files
------------

// File: rtl/fifo_sync_wd_if.sv
// Handshake bundle for fifo_sync_wd: control/data in, data/status out.
// master drives requests, slave is the FIFO.
interface fifo_sync_wd_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             clr;
   logic             wr_en;
   logic [WIDTH-1:0] din;
   logic             rd_en;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic             almost_full;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             udf;

   modport master (
      output clr, wr_en, din, rd_en,
      input  dout, empty, full, almost_full,
      input  count, ovf, udf
   );

   modport slave (
      input  clr, wr_en, din, rd_en,
      output dout, empty, full, almost_full,
      output count, ovf, udf
   );
endinterface

// File: rtl/fifo_sync_wd.sv
// Synchronous FIFO with registered read data, level flags
// and sticky overflow/underflow error flags.
module fifo_sync_wd #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input logic            clk,
   input logic            rst,
   fifo_sync_wd_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] dout_q;
   logic             ovf_q;
   logic             udf_q;

   logic full_w;
   logic empty_w;
   logic wa;
   logic ra;

   assign full_w  = (count_q == CW'(DEPTH));
   assign empty_w = (count_q == '0);

   // A write into a full FIFO is fine when a read frees a slot.
   assign wa = bus.wr_en & (~full_w | bus.rd_en);
   assign ra = bus.rd_en & ~empty_w;

   always_ff @(posedge clk) begin
      if (wa && !bus.clr) begin
         mem[wptr_q] <= bus.din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else if (bus.clr) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (wa) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (ra) begin
            dout_q <= mem[rptr_q];
            rptr_q <= rptr_q + AW'(1);
         end
         count_q <= count_q + CW'(wa) - CW'(ra);
         if (bus.wr_en && !wa) begin
            ovf_q <= 1'b1;
         end
         if (bus.rd_en && empty_w) begin
            udf_q <= 1'b1;
         end
      end
   end

   assign bus.dout        = dout_q;
   assign bus.count       = count_q;
   assign bus.empty       = empty_w;
   assign bus.full        = full_w;
   assign bus.almost_full = (count_q >= CW'(AFULL_LVL));
   assign bus.ovf         = ovf_q;
   assign bus.udf         = udf_q;
endmodule

// File: tb/tb_fifo_sync_wd.sv
// Directed bench for fifo_sync_wd (WIDTH=8, DEPTH=8, AFULL_LVL=6).
// Each task drives one scenario and checks against hand-computed values.
module tb_fifo_sync_wd;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fifo_sync_wd_if #(.WIDTH(8), .DEPTH(8)) bus ();

   fifo_sync_wd #(
      .WIDTH(8),
      .DEPTH(8),
      .AFULL_LVL(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.clr   = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = 8'h00;
   endtask

   task automatic fill_11_88();
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 8'((i + 1) * 8'h11);
         step();
      end
      idle();
   endtask

   task automatic chk_reset_vals(input string tag);
      checks++;
      if (bus.dout !== 8'h00 || bus.count !== 4'd0 ||
          bus.empty !== 1'b1 || bus.full !== 1'b0 ||
          bus.almost_full !== 1'b0 || bus.ovf !== 1'b0 ||
          bus.udf !== 1'b0) begin
         errors++;
         $display("FAIL %s: dout=%h cnt=%0d e=%b f=%b af=%b o=%b u=%b want 00 0 1 0 0 0 0",
                  tag, bus.dout, bus.count, bus.empty, bus.full,
                  bus.almost_full, bus.ovf, bus.udf);
      end
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      #11;
      chk_reset_vals("reset");
      rst = 1'b0;
      step();
      chk_reset_vals("post_reset_idle");
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 8'((i + 1) * 8'h11);
         step();
         checks++;
         if (bus.count !== 4'(i + 1) || bus.empty !== 1'b0 ||
             bus.almost_full !== (i + 1 >= 6) ||
             bus.full !== (i + 1 == 8)) begin
            errors++;
            $display("FAIL fill[%0d]: cnt=%0d e=%b af=%b f=%b want cnt=%0d",
                     i, bus.count, bus.empty, bus.almost_full,
                     bus.full, i + 1);
         end
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         bus.rd_en = 1'b1;
         step();
         checks++;
         if (bus.dout !== 8'((i + 1) * 8'h11) ||
             bus.count !== 4'(7 - i) ||
             bus.empty !== (i == 7)) begin
            errors++;
            $display("FAIL drain[%0d]: dout=%h cnt=%0d e=%b want %h %0d",
                     i, bus.dout, bus.count, bus.empty,
                     8'((i + 1) * 8'h11), 7 - i);
         end
      end
      idle();
      checks++;
      if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin
         errors++;
         $display("FAIL drain_flags: ovf=%b udf=%b want 0 0",
                  bus.ovf, bus.udf);
      end
   endtask

   task automatic test_overflow();
      fill_11_88();
      bus.wr_en = 1'b1;
      bus.din   = 8'hAA;
      step();
      idle();
      checks++;
      if (bus.count !== 4'd8 || bus.ovf !== 1'b1 ||
          bus.dout !== 8'h88) begin
         errors++;
         $display("FAIL ovf_set: cnt=%0d ovf=%b dout=%h want 8 1 88",
                  bus.count, bus.ovf, bus.dout);
      end
      for (int i = 0; i < 8; i++) begin
         bus.rd_en = 1'b1;
         step();
         checks++;
         if (bus.dout !== 8'((i + 1) * 8'h11) || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain[%0d]: dout=%h ovf=%b want %h 1",
                     i, bus.dout, bus.ovf, 8'((i + 1) * 8'h11));
         end
      end
      idle();
      bus.clr = 1'b1;
      step();
      idle();
      checks++;
      if (bus.ovf !== 1'b0 || bus.empty !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clr: ovf=%b empty=%b want 0 1",
                  bus.ovf, bus.empty);
      end
   endtask

   task automatic test_full_rw();
      fill_11_88();
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'hBB;
      step();
      idle();
      checks++;
      if (bus.dout !== 8'h11 || bus.count !== 4'd8 ||
          bus.ovf !== 1'b0 || bus.full !== 1'b1) begin
         errors++;
         $display("FAIL full_rw: dout=%h cnt=%0d ovf=%b f=%b want 11 8 0 1",
                  bus.dout, bus.count, bus.ovf, bus.full);
      end
      for (int i = 0; i < 8; i++) begin
         bus.rd_en = 1'b1;
         step();
      end
      idle();
      checks++;
      if (bus.dout !== 8'hBB || bus.empty !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_tail: dout=%h empty=%b want bb 1",
                  bus.dout, bus.empty);
      end
   endtask

   task automatic test_underflow();
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'h5C;
      step();
      idle();
      checks++;
      if (bus.udf !== 1'b1 || bus.dout !== 8'hBB ||
          bus.count !== 4'd1 || bus.empty !== 1'b0) begin
         errors++;
         $display("FAIL udf_set: udf=%b dout=%h cnt=%0d want 1 bb 1",
                  bus.udf, bus.dout, bus.count);
      end
      bus.rd_en = 1'b1;
      step();
      idle();
      checks++;
      if (bus.dout !== 8'h5C || bus.empty !== 1'b1 ||
          bus.udf !== 1'b1) begin
         errors++;
         $display("FAIL udf_read: dout=%h empty=%b udf=%b want 5c 1 1",
                  bus.dout, bus.empty, bus.udf);
      end
      bus.clr = 1'b1;
      step();
      idle();
      checks++;
      if (bus.udf !== 1'b0 || bus.dout !== 8'h5C) begin
         errors++;
         $display("FAIL udf_clr: udf=%b dout=%h want 0 5c",
                  bus.udf, bus.dout);
      end
   endtask

   task automatic test_stream();
      logic [7:0] q[$];
      logic [7:0] exp_dout;
      int         mcnt;
      int         sent;
      int         c;
      logic       w;
      logic       r;
      logic       wa;
      logic       ra;
      mcnt     = 0;
      sent     = 0;
      c        = 0;
      exp_dout = bus.dout;
      while ((sent < 20 || q.size() != 0) && c < 200) begin
         w = (sent < 20) && ((c % 4) != 3);
         r = (c >= 6) && (((c % 3) != 0) || sent >= 20);
         wa = w && (mcnt < 8 || r);
         ra = r && (mcnt > 0);
         bus.wr_en = w;
         bus.rd_en = r;
         bus.din   = 8'(sent * 37 + 5);
         step();
         if (ra) exp_dout = q.pop_front();
         if (wa) begin
            q.push_back(8'(sent * 37 + 5));
            sent++;
         end
         mcnt = mcnt + int'(wa) - int'(ra);
         checks++;
         if (bus.count !== 4'(mcnt) || bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL stream[%0d]: cnt=%0d dout=%h want %0d %h",
                     c, bus.count, bus.dout, mcnt, exp_dout);
         end
         c++;
      end
      idle();
      checks++;
      if (c >= 200 || bus.empty !== 1'b1) begin
         errors++;
         $display("FAIL stream_end: cycles=%0d empty=%b want <200 1",
                  c, bus.empty);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 8'(8'hC0 + i);
         step();
      end
      idle();
      bus.rd_en = 1'b1;
      step();
      idle();
      checks++;
      if (bus.count !== 4'd4 || bus.dout !== 8'hC0) begin
         errors++;
         $display("FAIL pre_rst: cnt=%0d dout=%h want 4 c0",
                  bus.count, bus.dout);
      end
      bus.wr_en = 1'b1;
      bus.din   = 8'hC5;
      step();
      idle();
      #3;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      #2;
      rst = 1'b0;
      step();
      chk_reset_vals("after_rst");
   endtask

   task automatic test_clr();
      fill_11_88();
      bus.wr_en = 1'b1;
      bus.din   = 8'hEE;
      step();
      idle();
      for (int i = 0; i < 5; i++) begin
         bus.rd_en = 1'b1;
         step();
      end
      idle();
      checks++;
      if (bus.count !== 4'd3 || bus.ovf !== 1'b1 ||
          bus.dout !== 8'h55) begin
         errors++;
         $display("FAIL pre_clr: cnt=%0d ovf=%b dout=%h want 3 1 55",
                  bus.count, bus.ovf, bus.dout);
      end
      bus.clr   = 1'b1;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'h99;
      step();
      idle();
      checks++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1 ||
          bus.ovf !== 1'b0 || bus.dout !== 8'h55) begin
         errors++;
         $display("FAIL clr: cnt=%0d e=%b ovf=%b dout=%h want 0 1 0 55",
                  bus.count, bus.empty, bus.ovf, bus.dout);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      idle();
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_rw();
      test_underflow();
      test_stream();
      test_reset_mid();
      test_clr();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
